ps2_scan_ctrl: RTL

//  Sequencer behind the PS/2 frame receiver. Consumes 11-bit frames, checks

---
 rtl/ps2_scan_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ps2_scan_ctrl.sv
// PS/2 scancode sequencer: frame check, E0/F0 prefix decode and an event FIFO.
// Define PS2_TIMEOUT_EN to abandon a pending prefix after TIMEOUT_CYC idle cycles.
module ps2_scan_ctrl #(
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned ERR_W       = 8,
    parameter int unsigned TIMEOUT_CYC = 100000
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          frame_valid_i,
    input  logic [10:0]                   frame_i,
    output logic                          ev_valid_o,
    input  logic                          ev_ready_i,
    output logic [7:0]                    ev_code_o,
    output logic                          ev_ext_o,
    output logic                          ev_break_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          ovf_o,
    input  logic                          ovf_clr_i,
    output logic [ERR_W-1:0]              err_cnt_o
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned LvlW = PtrW + 1;

    typedef enum logic [1:0] {StIdle, StExt, StBrk, StExtBrk} state_e;

    state_e            state_q, state_d, state_eff;
    logic [7:0]        byte_w;
    logic              frame_good, frame_bad, code_err, tmo_expire;
    logic              push, push_ok, pop, full, drop, err_inc;
    logic [9:0]        ev_new;
    logic [9:0]        mem_q [FIFO_DEPTH];
    logic [9:0]        head_q, head_d;
    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LvlW-1:0]   count_q, count_d;
    logic              ovf_q, ovf_d;
    logic [ERR_W-1:0]  err_q, err_d;

    assign byte_w     = frame_i[8:1];
    assign frame_good = frame_valid_i & ~frame_i[0] & frame_i[10] & (^frame_i[9:1]);
    assign frame_bad  = frame_valid_i & ~frame_good;

`ifdef PS2_TIMEOUT_EN
    localparam int unsigned TmoW = $clog2(TIMEOUT_CYC + 1);

    logic [TmoW-1:0] tmo_q, tmo_d;

    // Expiry cycle behaves as IDLE so a coincident frame starts a fresh sequence.
    assign tmo_expire = (state_q != StIdle) && (tmo_q == TmoW'(TIMEOUT_CYC));

    always_comb begin
        tmo_d = tmo_q + TmoW'(1);
        if (frame_valid_i || (state_q == StIdle) || tmo_expire) begin
            tmo_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic unused_tmo_cfg;

    assign unused_tmo_cfg = ^TIMEOUT_CYC;
    assign tmo_expire     = 1'b0;
`endif

    assign state_eff = tmo_expire ? StIdle : state_q;

    always_comb begin
        state_d  = state_eff;
        push     = 1'b0;
        ev_new   = {byte_w, 2'b00};
        code_err = 1'b0;
        if (frame_good) begin
            unique case (state_eff)
                StIdle: begin
                    if (byte_w == 8'hE0) begin
                        state_d = StExt;
                    end else if (byte_w == 8'hF0) begin
                        state_d = StBrk;
                    end else if ((byte_w == 8'h00) || (byte_w == 8'hFF)) begin
                        code_err = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                StExt: begin
                    if (byte_w == 8'hF0) begin
                        state_d = StExtBrk;
                    end else if (byte_w != 8'hE0) begin
                        push    = 1'b1;
                        ev_new  = {byte_w, 2'b10};
                        state_d = StIdle;
                    end
                end
                StBrk: begin
                    if (byte_w == 8'hE0) begin
                        state_d = StExtBrk;
                    end else if (byte_w != 8'hF0) begin
                        push    = 1'b1;
                        ev_new  = {byte_w, 2'b01};
                        state_d = StIdle;
                    end
                end
                StExtBrk: begin
                    if ((byte_w != 8'hE0) && (byte_w != 8'hF0)) begin
                        push    = 1'b1;
                        ev_new  = {byte_w, 2'b11};
                        state_d = StIdle;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    assign err_inc = frame_bad | code_err | tmo_expire;

    always_comb begin
        err_d = err_q;
        if (err_inc && (err_q != {ERR_W{1'b1}})) begin
            err_d = err_q + ERR_W'(1);
        end
    end

    assign ev_valid_o = (count_q != '0);
    assign full       = (count_q == LvlW'(FIFO_DEPTH));
    assign pop        = ev_valid_o & ev_ready_i;
    assign push_ok    = push & (~full | pop);
    assign drop       = push & full & ~pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        if (push_ok && !pop) begin
            count_d = count_q + LvlW'(1);
        end else if (!push_ok && pop) begin
            count_d = count_q - LvlW'(1);
        end
    end

    // Head register: the pushed entry becomes head if nothing older survives this cycle.
    always_comb begin
        head_d = head_q;
        if (count_d != '0) begin
            if ((count_q == '0) || ((count_q == LvlW'(1)) && pop)) begin
                head_d = ev_new;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    assign ovf_d = (ovf_q & ~ovf_clr_i) | drop;

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= ev_new;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= StIdle;
            head_q   <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            err_q    <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign ev_code_o    = head_q[9:2];
    assign ev_ext_o     = head_q[1];
    assign ev_break_o   = head_q[0];
    assign fifo_level_o = count_q;
    assign ovf_o        = ovf_q;
    assign err_cnt_o    = err_q;

endmodule
